// File: rtl/score_argmax.sv
// Sequential argmax over NUM_CLASSES signed scores, one compare per cycle after a start pulse.
// Define SCORE_ARGMAX_TOP2_MARGIN_EN to also track the runner-up and report best-minus-second margin.
module score_argmax #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_CLASSES*DATA_W-1:0] scores,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              digit,
    output logic [DATA_W-1:0]             max_score,
    output logic [DATA_W:0]               margin
);

    typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  snap_q [NUM_CLASSES];
    logic signed [DATA_W-1:0]  best_q;
    logic [IDX_W-1:0]          best_idx_q;
    logic [IDX_W-1:0]          idx_q;
    logic signed [DATA_W-1:0]  cand;
    logic                      take;

    assign cand = snap_q[idx_q];
    assign take = cand > best_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StScan;
            StScan:   if (idx_q == LastIdx) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    // Snapshot and running best; ties keep the lower index because only strictly greater replaces.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(NUM_CLASSES); k++) snap_q[k] <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            digit      <= '0;
            max_score  <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state_q == StFinish);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                            snap_q[k] <= scores[k*DATA_W +: DATA_W];
                        end
                        best_q     <= scores[DATA_W-1:0];
                        best_idx_q <= '0;
                        idx_q      <= IDX_W'(1);
                    end
                end
                StScan: begin
                    if (take) begin
                        best_q     <= cand;
                        best_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + 1'b1;
                end
                StFinish: begin
                    digit     <= best_idx_q;
                    max_score <= best_q;
                end
                default: ;
            endcase
        end
    end

`ifdef SCORE_ARGMAX_TOP2_MARGIN_EN
    localparam logic signed [DATA_W-1:0] MinScore = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] second_q;
    logic [DATA_W:0]          margin_q;
    logic [DATA_W:0]          diff;

    // Sign-extend both operands so extreme values cannot overflow.
    assign diff = {best_q[DATA_W-1], best_q} - {second_q[DATA_W-1], second_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            second_q <= '0;
            margin_q <= '0;
        end else begin
            case (state_q)
                StIdle:   if (start) second_q <= MinScore;
                StScan: begin
                    if (take) begin
                        second_q <= best_q;
                    end else if (cand >= second_q) begin
                        second_q <= cand;
                    end
                end
                StFinish: margin_q <= diff;
                default: ;
            endcase
        end
    end

    assign margin = margin_q;
`else
    assign margin = '0;
`endif

endmodule

// File: tb/tb_score_argmax.sv
// Randomised and directed bench for score_argmax against a top-level argmax reference model.
module tb_score_argmax;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [NC*DW-1:0]  scores;
    logic              busy;
    logic              done;
    logic [IW-1:0]     digit;
    logic [DW-1:0]     max_score;
    logic [DW:0]       margin;

    int checks;
    int failures;

    logic signed [DW-1:0] sc [NC];
    logic [IW-1:0]        prev_digit;
    logic [IW-1:0]        m_digit;
    logic [DW-1:0]        m_max;
    logic [DW:0]          m_margin;

    score_argmax #(
        .NUM_CLASSES(NC),
        .DATA_W     (DW),
        .IDX_W      (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .scores   (scores),
        .busy     (busy),
        .done     (done),
        .digit    (digit),
        .max_score(max_score),
        .margin   (margin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: first index of the maximum, runner-up is the max of all other entries.
    task automatic model();
        longint best, second;
        int     d;
        best = longint'(sc[0]);
        d = 0;
        for (int k = 1; k < NC; k++) begin
            if (longint'(sc[k]) > best) begin
                best = longint'(sc[k]);
                d = k;
            end
        end
        second = -(longint'(1) << (DW - 1));
        for (int k = 0; k < NC; k++) begin
            if (k != d && longint'(sc[k]) > second) second = longint'(sc[k]);
        end
        m_digit = IW'(d);
        m_max   = DW'(best);
`ifdef SCORE_ARGMAX_TOP2_MARGIN_EN
        m_margin = (DW+1)'(best - second);
`else
        m_margin = '0;
`endif
    endtask

    task automatic pack();
        for (int k = 0; k < NC; k++) scores[k*DW +: DW] = sc[k];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes we are #1 after an edge with the DUT idle.
    task automatic do_scan(input string tag);
        int n;
        model();
        pack();
        start = 1'b1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n = i;
            if (i == 1) begin
                start = 1'b0;
                check({tag, "_busy"}, 64'(busy), 64'd1);
                check({tag, "_hold"}, 64'(digit), 64'(prev_digit));
            end
            if (done) break;
        end
        check({tag, "_latency"}, 64'(n - 1), 64'(NC));
        check({tag, "_digit"}, 64'(digit), 64'(m_digit));
        check({tag, "_max"}, 64'(max_score), 64'(m_max));
        check({tag, "_margin"}, 64'(margin), 64'(m_margin));
        check({tag, "_idle"}, 64'(busy), 64'd0);
        prev_digit = m_digit;
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  dones;
        logic [IW-1:0]  s_digit;
        logic [DW-1:0]  s_max;
        logic [DW:0]    s_margin;
        logic [DW-1:0]  ext [4];

        checks = 0;
        failures = 0;
        prev_digit = '0;
        start = 1'b0;
        scores = '0;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_digit", 64'(digit), 64'd0);
        check("rst_max", 64'(max_score), 64'd0);
        check("rst_margin", 64'(margin), 64'd0);
        reset = 1'b1;
        tick();

        sc = '{32'sd5, -32'sd3, 32'sd9, 32'sd2, 32'sd0, 32'sd1, -32'sd8, 32'sd4, 32'sd7, 32'sd3};
        do_scan("t1");

        for (int k = 0; k < NC; k++) sc[k] = 32'h0000_0010;
        do_scan("t2_eq");

        for (int k = 0; k < NC; k++) sc[k] = 32'h8000_0000;
        sc[9] = 32'h7FFF_FFFF;
        do_scan("t3_ext");

        // Start while busy must be ignored and the snapshot must shield the scan.
        sc = '{32'sd1, 32'sd2, 32'sd3, 32'sd40, 32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd10};
        model();
        s_digit = m_digit; s_max = m_max; s_margin = m_margin;
        pack();
        start = 1'b1;
        dones = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            start = 1'b0;
            if (i == 4) begin
                for (int k = 0; k < NC; k++) scores[k*DW +: DW] = 32'd100 + 32'(k);
                start = 1'b1;
            end
            if (done) dones++;
        end
        check("t4_dones", 64'(dones), 64'd1);
        check("t4_digit", 64'(digit), 64'(s_digit));
        check("t4_max", 64'(max_score), 64'(s_max));
        check("t4_margin", 64'(margin), 64'(s_margin));
        prev_digit = s_digit;

        // Reset mid-scan aborts with no done.
        pack();
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_digit", 64'(digit), 64'd0);
        check("t5_max", 64'(max_score), 64'd0);
        check("t5_margin", 64'(margin), 64'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 2) reset = 1'b1;
            if (done) dones++;
        end
        check("t5_nodone", 64'(dones), 64'd0);
        prev_digit = '0;
        for (int k = 0; k < NC; k++) sc[k] = DW'(k);
        sc[3] = 32'sd1000;
        do_scan("t5_after");

        // Back-to-back: do_scan returns one cycle after done, i.e. the cycle after done.
        for (int k = 0; k < NC; k++) sc[k] = -32'sd5;
        sc[7] = 32'sd77;
        do_scan("t6_b2b");

        ext = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int it = 0; it < 30; it++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < NC; k++) begin
                if (mode == 0) sc[k] = $urandom;
                else if (mode == 1) sc[k] = DW'(int'($urandom_range(0, 4)) - 2);
                else sc[k] = ext[$urandom_range(0, 3)];
            end
            repeat ($urandom_range(0, 2)) tick();
            do_scan($sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
